// File: rtl/cr_clic_pkg.sv
// rtl/cr_clic_pkg.sv - shared defaults, FSM encoding and level helper for the CLIC arbiter
// Contents:
//   CLICINTNUM_DEF / GRP_SIZE_DEF / ID_WIDTH_DEF : default sizing
//   arb_state_e                                  : arbiter FSM states
//   level_of()                                   : clicintctl -> interrupt level
package cr_clic_pkg;

   localparam int CLICINTNUM_DEF = 80;
   localparam int GRP_SIZE_DEF   = 8;
   localparam int ID_WIDTH_DEF   = 12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } arb_state_e;

   // Bits below the level field are not part of the level and read as ones.
   function automatic logic [7:0] level_of(input logic [7:0] ctl, input logic [3:0] nlbits);
      if (nlbits >= 4'd8) begin
         return ctl;
      end
      return ctl | (8'hff >> nlbits);
   endfunction

endpackage

// File: rtl/cr_clic_arb_grp.sv
// rtl/cr_clic_arb_grp.sv - combinational compare of one source group against the running best
// Ports:
//   base_id                        : id of the first source in this group
//   req/ctl/mode/hv                : per-source candidate attributes (ctl 8 bits each)
//   best_in_vld/id/ctl/mode/hv     : running best entering this group
//   best_out_vld/id/ctl/mode/hv    : running best after this group
module cr_clic_arb_grp
   import cr_clic_pkg::*;
#(
   parameter int GRP_SIZE = GRP_SIZE_DEF,
   parameter int ID_WIDTH = ID_WIDTH_DEF
) (
   input  logic [ID_WIDTH-1:0]   base_id,
   input  logic [GRP_SIZE-1:0]   req,
   input  logic [8*GRP_SIZE-1:0] ctl,
   input  logic [GRP_SIZE-1:0]   mode,
   input  logic [GRP_SIZE-1:0]   hv,
   input  logic                  best_in_vld,
   input  logic [ID_WIDTH-1:0]   best_in_id,
   input  logic [7:0]            best_in_ctl,
   input  logic                  best_in_mode,
   input  logic                  best_in_hv,
   output logic                  best_out_vld,
   output logic [ID_WIDTH-1:0]   best_out_id,
   output logic [7:0]            best_out_ctl,
   output logic                  best_out_mode,
   output logic                  best_out_hv
);

   logic [7:0]          c_ctl;
   logic [ID_WIDTH-1:0] c_id;
   logic                win;

   // Chain of pairwise compares: only requesters compete; M beats U,
   // then larger ctl, then smaller id.
   always_comb begin
      best_out_vld  = best_in_vld;
      best_out_id   = best_in_id;
      best_out_ctl  = best_in_ctl;
      best_out_mode = best_in_mode;
      best_out_hv   = best_in_hv;
      c_ctl         = '0;
      c_id          = '0;
      win           = 1'b0;
      for (int i = 0; i < GRP_SIZE; i++) begin
         c_ctl = ctl[8*i +: 8];
         c_id  = base_id + ID_WIDTH'(i);
         win   = 1'b0;
         if (req[i]) begin
            if (!best_out_vld)                win = 1'b1;
            else if (mode[i] != best_out_mode) win = mode[i];
            else if (c_ctl != best_out_ctl)   win = (c_ctl > best_out_ctl);
            else                              win = (c_id < best_out_id);
         end
         if (win) begin
            best_out_vld  = 1'b1;
            best_out_id   = c_id;
            best_out_ctl  = c_ctl;
            best_out_mode = mode[i];
            best_out_hv   = hv[i];
         end
      end
   end

endmodule

// File: rtl/cr_clic_arb_seq.sv
// rtl/cr_clic_arb_seq.sv - sequential CLIC interrupt arbiter, one source group per cycle
// Ports:
//   arb_clk, cpurst_b                  : clock, synchronous active-low reset
//   kid_arb_int_req/ctl/mode/hv        : per-source pending, clicintctl, mode, hv
//   kid_arb_updt                       : source state changed, restart the scan
//   ctrl_arb_nlbits                    : number of level bits in clicintctl
//   arb_ctrl_int_vld/id/il/mode/hv     : registered winner of the last completed round
//   arb_busy                           : scan round in progress
module cr_clic_arb_seq
   import cr_clic_pkg::*;
#(
   parameter int CLICINTNUM = CLICINTNUM_DEF,
   parameter int GRP_SIZE   = GRP_SIZE_DEF,
   parameter int ID_WIDTH   = ID_WIDTH_DEF
) (
   input  logic                    arb_clk,
   input  logic                    cpurst_b,
   input  logic [CLICINTNUM-1:0]   kid_arb_int_req,
   input  logic [8*CLICINTNUM-1:0] kid_arb_int_ctl,
   input  logic [CLICINTNUM-1:0]   kid_arb_int_mode,
   input  logic [CLICINTNUM-1:0]   kid_arb_int_hv,
   input  logic                    kid_arb_updt,
   input  logic [3:0]              ctrl_arb_nlbits,
   output logic                    arb_ctrl_int_vld,
   output logic [ID_WIDTH-1:0]     arb_ctrl_int_id,
   output logic [7:0]              arb_ctrl_int_il,
   output logic                    arb_ctrl_int_mode,
   output logic                    arb_ctrl_int_hv,
   output logic                    arb_busy
);

   localparam int NGRP = CLICINTNUM / GRP_SIZE;
   localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam logic [CW-1:0] LAST_GRP = CW'(NGRP - 1);

   arb_state_e          state;
   logic [CW-1:0]       grp_cnt;
   logic                best_vld;
   logic [ID_WIDTH-1:0] best_id;
   logic [7:0]          best_ctl;
   logic                best_mode;
   logic                best_hv;

   logic                nxt_vld;
   logic [ID_WIDTH-1:0] nxt_id;
   logic [7:0]          nxt_ctl;
   logic                nxt_mode;
   logic                nxt_hv;

   cr_clic_arb_grp #(
      .GRP_SIZE (GRP_SIZE),
      .ID_WIDTH (ID_WIDTH)
   ) u_grp (
      .base_id       (ID_WIDTH'(grp_cnt) * ID_WIDTH'(GRP_SIZE)),
      .req           (kid_arb_int_req [GRP_SIZE*grp_cnt +: GRP_SIZE]),
      .ctl           (kid_arb_int_ctl [8*GRP_SIZE*grp_cnt +: 8*GRP_SIZE]),
      .mode          (kid_arb_int_mode[GRP_SIZE*grp_cnt +: GRP_SIZE]),
      .hv            (kid_arb_int_hv  [GRP_SIZE*grp_cnt +: GRP_SIZE]),
      .best_in_vld   (best_vld),
      .best_in_id    (best_id),
      .best_in_ctl   (best_ctl),
      .best_in_mode  (best_mode),
      .best_in_hv    (best_hv),
      .best_out_vld  (nxt_vld),
      .best_out_id   (nxt_id),
      .best_out_ctl  (nxt_ctl),
      .best_out_mode (nxt_mode),
      .best_out_hv   (nxt_hv)
   );

   assign arb_busy = (state != ST_IDLE);

   always_ff @(posedge arb_clk) begin
      if (!cpurst_b) begin
         state             <= ST_IDLE;
         grp_cnt           <= '0;
         best_vld          <= 1'b0;
         best_id           <= '0;
         best_ctl          <= '0;
         best_mode         <= 1'b0;
         best_hv           <= 1'b0;
         arb_ctrl_int_vld  <= 1'b0;
         arb_ctrl_int_id   <= '0;
         arb_ctrl_int_il   <= '0;
         arb_ctrl_int_mode <= 1'b0;
         arb_ctrl_int_hv   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|kid_arb_int_req || kid_arb_updt) begin
                  state   <= ST_SCAN;
                  grp_cnt <= '0;
               end
            end
            ST_SCAN: begin
               // A change in source state restarts the round, even on the last group.
               if (kid_arb_updt) begin
                  grp_cnt  <= '0;
                  best_vld <= 1'b0;
                  best_id  <= '0;
                  best_ctl <= '0;
                  best_mode <= 1'b0;
                  best_hv  <= 1'b0;
               end else begin
                  best_vld  <= nxt_vld;
                  best_id   <= nxt_id;
                  best_ctl  <= nxt_ctl;
                  best_mode <= nxt_mode;
                  best_hv   <= nxt_hv;
                  if (grp_cnt == LAST_GRP) begin
                     state   <= ST_DONE;
                     grp_cnt <= '0;
                  end else begin
                     grp_cnt <= grp_cnt + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (!kid_arb_updt) begin
                  arb_ctrl_int_vld  <= best_vld;
                  arb_ctrl_int_id   <= best_vld ? best_id : '0;
                  arb_ctrl_int_il   <= best_vld ? level_of(best_ctl, ctrl_arb_nlbits) : 8'h00;
                  arb_ctrl_int_mode <= best_vld & best_mode;
                  arb_ctrl_int_hv   <= best_vld & best_hv;
                  state             <= (|kid_arb_int_req) ? ST_SCAN : ST_IDLE;
               end else begin
                  state <= ST_SCAN;
               end
               grp_cnt   <= '0;
               best_vld  <= 1'b0;
               best_id   <= '0;
               best_ctl  <= '0;
               best_mode <= 1'b0;
               best_hv   <= 1'b0;
            end
            default: begin
               state   <= ST_IDLE;
               grp_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cr_clic_arb_seq.sv
// tb/tb_cr_clic_arb_seq.sv - self-checking bench for cr_clic_arb_seq against a whole-array reference model
module tb_cr_clic_arb_seq;

   localparam int N = 80;

   logic           clk = 1'b0;
   logic           rst_b;
   logic [N-1:0]   req;
   logic [8*N-1:0] ctl;
   logic [N-1:0]   mode;
   logic [N-1:0]   hv;
   logic           updt;
   logic [3:0]     nlbits;
   logic           o_vld;
   logic [11:0]    o_id;
   logic [7:0]     o_il;
   logic           o_mode;
   logic           o_hv;
   logic           busy;
   logic [22:0]    obs;
   logic [22:0]    exp_out;
   int             n_chk = 0;
   int             n_pass = 0;

   assign obs = {o_vld, o_id, o_il, o_mode, o_hv};

   always #5 clk = ~clk;

   cr_clic_arb_seq dut (
      .arb_clk           (clk),
      .cpurst_b          (rst_b),
      .kid_arb_int_req   (req),
      .kid_arb_int_ctl   (ctl),
      .kid_arb_int_mode  (mode),
      .kid_arb_int_hv    (hv),
      .kid_arb_updt      (updt),
      .ctrl_arb_nlbits   (nlbits),
      .arb_ctrl_int_vld  (o_vld),
      .arb_ctrl_int_id   (o_id),
      .arb_ctrl_int_il   (o_il),
      .arb_ctrl_int_mode (o_mode),
      .arb_ctrl_int_hv   (o_hv),
      .arb_busy          (busy)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_srcs();
      req  = '0;
      ctl  = '0;
      mode = '0;
      hv   = '0;
   endtask

   task automatic set_src(input int id, input logic [7:0] c, input logic m, input logic h);
      req[id]         = 1'b1;
      ctl[8*id +: 8]  = c;
      mode[id]        = m;
      hv[id]          = h;
   endtask

   // Reference: argmax over all requesters of (mode, ctl); ties keep the first (lowest) id.
   function automatic logic [22:0] model();
      int         win;
      logic [8:0] kw;
      logic [8:0] ki;
      logic [7:0] il;
      win = -1;
      kw  = '0;
      for (int i = 0; i < N; i++) begin
         if (req[i]) begin
            ki = {mode[i], ctl[8*i +: 8]};
            if (win < 0 || ki > kw) begin
               win = i;
               kw  = ki;
            end
         end
      end
      if (win < 0) return '0;
      il = ctl[8*win +: 8];
      for (int b = 0; b < 8; b++) begin
         if (b < 8 - int'(nlbits)) il[b] = 1'b1;
      end
      return {1'b1, 12'(win), il, mode[win], hv[win]};
   endfunction

   task automatic test_reset();
      rst_b = 1'b0;
      updt  = 1'b0;
      nlbits = 4'd3;
      clear_srcs();
      set_src(7, 8'h40, 1'b1, 1'b1);
      repeat (3) cyc();
      n_chk++;
      if (obs !== 23'h0 || busy !== 1'b0) $display("FAIL reset: outputs=%h busy=%b, required 0/0", obs, busy);
      else n_pass++;
      exp_out = '0;
   endtask

   task automatic test_single();
      clear_srcs();
      set_src(5, 8'hE0, 1'b1, 1'b0);
      nlbits = 4'd3;
      rst_b = 1'b1;
      cyc();
      n_chk++;
      if (busy !== 1'b1) $display("FAIL single_busy: busy=%b required 1", busy);
      else n_pass++;
      for (int k = 1; k <= 10; k++) begin
         cyc();
         n_chk++;
         if (obs !== 23'h0) $display("FAIL single_hold cyc%0d: outputs=%h required 0", k, obs);
         else n_pass++;
      end
      cyc();
      exp_out = {1'b1, 12'd5, 8'hFF, 1'b1, 1'b0};
      n_chk++;
      if (obs !== exp_out || model() !== exp_out)
         $display("FAIL single: outputs=%h required %h", obs, exp_out);
      else n_pass++;
   endtask

   task automatic test_mode();
      clear_srcs();
      set_src(3, 8'hFF, 1'b0, 1'b1);
      set_src(70, 8'h20, 1'b1, 1'b0);
      nlbits = 4'd8;
      updt = 1'b1;
      cyc();
      updt = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         cyc();
         n_chk++;
         if (obs !== exp_out) $display("FAIL mode_hold cyc%0d: outputs=%h required %h", k, obs, exp_out);
         else n_pass++;
      end
      cyc();
      exp_out = {1'b1, 12'd70, 8'h20, 1'b1, 1'b0};
      n_chk++;
      if (obs !== exp_out) $display("FAIL mode_beats_ctl: outputs=%h required %h", obs, exp_out);
      else n_pass++;
   endtask

   task automatic test_tie();
      clear_srcs();
      set_src(40, 8'h80, 1'b1, 1'b0);
      set_src(10, 8'h80, 1'b1, 1'b1);
      nlbits = 4'd1;
      updt = 1'b1;
      cyc();
      updt = 1'b0;
      repeat (11) cyc();
      exp_out = {1'b1, 12'd10, 8'hFF, 1'b1, 1'b1};
      n_chk++;
      if (obs !== exp_out) $display("FAIL tie_low_id: outputs=%h required %h", obs, exp_out);
      else n_pass++;
   endtask

   // Restart with `first` inputs, change to the single source `second` with
   // updt when grp_cnt equals `at_grp`; the new winner appears 11 edges later.
   task automatic abort_round(input string name, input int first, input int at_grp, input int second);
      clear_srcs();
      set_src(first, 8'h60, 1'b1, 1'b0);
      nlbits = 4'd2;
      updt = 1'b1;
      cyc();
      updt = 1'b0;
      repeat (at_grp) cyc();
      clear_srcs();
      set_src(second, 8'h10, 1'b0, 1'b1);
      updt = 1'b1;
      cyc();
      updt = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         cyc();
         n_chk++;
         if (obs !== exp_out) $display("FAIL %s_hold cyc%0d: outputs=%h required %h", name, k, obs, exp_out);
         else n_pass++;
      end
      cyc();
      exp_out = model();
      n_chk++;
      if (obs !== exp_out || obs[21:10] !== 12'(second))
         $display("FAIL %s: outputs=%h required %h", name, obs, exp_out);
      else n_pass++;
   endtask

   task automatic test_abort();
      clear_srcs();
      set_src(12, 8'hC0, 1'b1, 1'b0);
      nlbits = 4'd4;
      updt = 1'b1;
      cyc();
      updt = 1'b0;
      repeat (11) cyc();
      exp_out = {1'b1, 12'd12, 8'hCF, 1'b1, 1'b0};
      n_chk++;
      if (obs !== exp_out) $display("FAIL abort_pre: outputs=%h required %h", obs, exp_out);
      else n_pass++;
      abort_round("abort_grp4", 12, 4, 50);
   endtask

   task automatic test_last_grp_updt();
      abort_round("updt_last_grp", 20, 9, 60);
   endtask

   task automatic test_mid_reset();
      clear_srcs();
      set_src(33, 8'hA0, 1'b1, 1'b1);
      updt = 1'b1;
      cyc();
      updt = 1'b0;
      repeat (6) cyc();
      rst_b = 1'b0;
      cyc();
      n_chk++;
      if (obs !== 23'h0 || busy !== 1'b0) $display("FAIL mid_reset: outputs=%h busy=%b, required 0/0", obs, busy);
      else n_pass++;
      rst_b = 1'b1;
      exp_out = '0;
   endtask

   task automatic test_random();
      for (int it = 0; it < 24; it++) begin
         clear_srcs();
         for (int i = 0; i < N; i++) begin
            req[i]        = ($urandom_range(0, 9) == 0) && (it % 6 != 5);
            ctl[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3) << 6);
            mode[i]       = 1'($urandom);
            hv[i]         = 1'($urandom);
         end
         nlbits = 4'($urandom_range(0, 10));
         updt = 1'b1;
         cyc();
         updt = 1'b0;
         for (int k = 1; k <= 10; k++) begin
            cyc();
            n_chk++;
            if (obs !== exp_out) $display("FAIL rand%0d_hold cyc%0d: outputs=%h required %h", it, k, obs, exp_out);
            else n_pass++;
         end
         cyc();
         exp_out = model();
         n_chk++;
         if (obs !== exp_out) $display("FAIL rand%0d: outputs=%h required %h", it, obs, exp_out);
         else n_pass++;
      end
   endtask

   task automatic test_drop();
      clear_srcs();
      set_src(44, 8'h55, 1'b0, 1'b0);
      updt = 1'b1;
      cyc();
      updt = 1'b0;
      repeat (11) cyc();
      exp_out = model();
      clear_srcs();
      updt = 1'b1;
      cyc();
      updt = 1'b0;
      repeat (11) cyc();
      n_chk++;
      if (obs !== 23'h0) $display("FAIL drop: outputs=%h required 0", obs);
      else n_pass++;
      cyc();
      n_chk++;
      if (busy !== 1'b0) $display("FAIL drop_idle: busy=%b required 0", busy);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_mode();
      test_tie();
      test_abort();
      test_last_grp_updt();
      test_mid_reset();
      test_random();
      test_drop();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
